// File: rtl/imm_packer.sv
// imm_packer: packs a 64-bit two's-complement immediate into the immediate
// fields of a 32-bit instruction template. Formats: I, S, B, U, J, SHAMT, ZIMM.
// An immediate that does not fit the selected format raises out_err. The packed
// (truncated) fields are still emitted in that case.
//
// Two-stage pipeline:
//   stage 1 registers the request and range-checks it;
//   stage 2 registers the packed instruction and the error flag.
// Both stages advance together under a single enable, en = !out_valid | out_ready.
// This enable is also driven out as in_ready.
//
// Optional feature: define IMM_PACKER_ERR_CNT_EN to build a saturating counter.
// It counts delivered results that had out_err set. Without the macro,
// err_count is tied to zero and no counter register exists.

module imm_packer #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [63:0]          in_imm,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    FmtI     = 3'd0,
    FmtS     = 3'd1,
    FmtB     = 3'd2,
    FmtU     = 3'd3,
    FmtJ     = 3'd4,
    FmtShamt = 3'd5,
    FmtZimm  = 3'd6,
    FmtRsvd  = 3'd7
  } fmt_e;

  // Global pipeline advance: the output slot is free or is being drained.
  logic en;

  // Stage 1 state.
  logic        s1_valid_q;
  fmt_e        s1_fmt_q;
  logic [63:0] s1_imm_q;
  logic [31:0] s1_instr_q;

  // Stage 2 state (drives the outputs directly).
  logic        s2_valid_q;
  logic [31:0] s2_instr_q;
  logic        s2_err_q;

  // Range-check terms on the stage-1 immediate.
  logic sext12;     // fits signed 12-bit: -2048..2047
  logic sext13;     // fits signed 13-bit: -4096..4095
  logic sext21;     // fits signed 21-bit
  logic sext32;     // fits signed 32-bit
  logic zext6;      // unsigned value <= 63
  logic zext5;      // unsigned value <= 31
  logic low12_zero; // low 12 bits clear, as U-type requires
  logic odd;        // bit 0 set; B and J targets must be even

  // Combinational result of stage 1, captured by stage 2.
  logic [31:0] pack_instr;
  logic        pack_err;

  assign en        = !s2_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;

  // A value fits in N signed bits when bits [63:N-1] are all zeros or all ones.
  assign sext12     = (&s1_imm_q[63:11]) || !(|s1_imm_q[63:11]);
  assign sext13     = (&s1_imm_q[63:12]) || !(|s1_imm_q[63:12]);
  assign sext21     = (&s1_imm_q[63:20]) || !(|s1_imm_q[63:20]);
  assign sext32     = (&s1_imm_q[63:31]) || !(|s1_imm_q[63:31]);
  assign zext6      = !(|s1_imm_q[63:6]);
  assign zext5      = !(|s1_imm_q[63:5]);
  assign low12_zero = !(|s1_imm_q[11:0]);
  assign odd        = s1_imm_q[0];

  // Stage 1 register: capture the accepted request, or a bubble when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= FmtI;
      s1_imm_q   <= '0;
      s1_instr_q <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      // Request fields are only meaningful with in_valid; skip the load otherwise.
      if (in_valid) begin
        s1_fmt_q   <= fmt_e'(in_fmt);
        s1_imm_q   <= in_imm;
        s1_instr_q <= in_instr;
      end
    end
  end

  // Field packing and range check for the stage-1 request.
  always_comb begin
    pack_instr = s1_instr_q;
    pack_err   = 1'b0;
    unique case (s1_fmt_q)
      FmtI: begin
        pack_instr[31:20] = s1_imm_q[11:0];
        pack_err          = !sext12;
      end
      FmtS: begin
        pack_instr[31:25] = s1_imm_q[11:5];
        pack_instr[11:7]  = s1_imm_q[4:0];
        pack_err          = !sext12;
      end
      FmtB: begin
        pack_instr[31]    = s1_imm_q[12];
        pack_instr[30:25] = s1_imm_q[10:5];
        pack_instr[11:8]  = s1_imm_q[4:1];
        pack_instr[7]     = s1_imm_q[11];
        // With a signed 13-bit fit and an even value, the range is -4096..4094.
        pack_err          = !sext13 || odd;
      end
      FmtU: begin
        pack_instr[31:12] = s1_imm_q[31:12];
        pack_err          = !low12_zero || !sext32;
      end
      FmtJ: begin
        pack_instr[31]    = s1_imm_q[20];
        pack_instr[30:21] = s1_imm_q[10:1];
        pack_instr[20]    = s1_imm_q[11];
        pack_instr[19:12] = s1_imm_q[19:12];
        pack_err          = !sext21 || odd;
      end
      FmtShamt: begin
        pack_instr[25:20] = s1_imm_q[5:0];
        pack_err          = !zext6;
      end
      FmtZimm: begin
        pack_instr[19:15] = s1_imm_q[4:0];
        pack_err          = !zext5;
      end
      FmtRsvd: begin
        // Reserved format passes the template through unchanged and always errors.
        pack_err = 1'b1;
      end
    endcase
  end

  // Stage 2 register: the output slot. It holds steady while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= pack_instr;
        s2_err_q   <= pack_err;
      end
    end
  end

`ifdef IMM_PACKER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Count erroneous results at the moment they are consumed. Saturate at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Testbench for imm_packer.
// A driver pushes expected results into a scoreboard queue when a request is
// accepted. An independent monitor compares every presented output against
// the queue head. The expected results come from a reference model written
// directly from the field/range rules, using signed arithmetic.

module tb_imm_packer;

  localparam int unsigned CW   = 2;
  localparam int unsigned MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_fmt;
  logic [63:0]   in_imm;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] err_count;

  imm_packer #(.ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_imm    (in_imm),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   exp_cnt   = 0;
  bit   rand_ready = 1'b0;

  longint bnd[22] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                      -1048577, -1048576, 1048574, 1048575, 1048576, 31, 32, 63, 64, 0,
                      -64'sd2147483649, 64'sd2147483647, 64'sd2147483648};

  localparam longint UMin = -64'sd2147483648;
  localparam longint UMax = 64'sd2147483647;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, stated directly from the format rules.
  function automatic void ref_model(input logic [2:0] f, input logic [63:0] imm,
                                    input logic [31:0] tmpl, output exp_t e);
    longint s;
    s       = imm;
    e.instr = tmpl;
    e.err   = 1'b0;
    case (f)
      3'd0: begin
        e.instr[31:20] = imm[11:0];
        e.err = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        e.instr[31:25] = imm[11:5];
        e.instr[11:7]  = imm[4:0];
        e.err = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        e.instr[31] = imm[12]; e.instr[30:25] = imm[10:5];
        e.instr[11:8] = imm[4:1]; e.instr[7] = imm[11];
        e.err = (s < -4096) || (s > 4094) || (s % 2 != 0);
      end
      3'd3: begin
        e.instr[31:12] = imm[31:12];
        e.err = (s % 4096 != 0) || (s < UMin) || (s > UMax);
      end
      3'd4: begin
        e.instr[31] = imm[20]; e.instr[30:21] = imm[10:1];
        e.instr[20] = imm[11]; e.instr[19:12] = imm[19:12];
        e.err = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      end
      3'd5: begin
        e.instr[25:20] = imm[5:0];
        e.err = imm > 64'd63;
      end
      3'd6: begin
        e.instr[19:15] = imm[4:0];
        e.err = imm > 64'd31;
      end
      default: e.err = 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] rand_imm();
    longint v;
    logic [31:0] w;
    case ($urandom_range(0, 5))
      0: v = {$urandom, $urandom};
      1: v = longint'($urandom_range(0, 20000)) - 10000;
      2: v = bnd[$urandom_range(0, 21)] + longint'($urandom_range(0, 2)) - 1;
      3: begin
        w = $urandom & 32'hFFFF_F000;
        v = ($urandom_range(0, 3) == 0) ? longint'({32'd0, w}) : longint'(signed'(w));
      end
      4: v = longint'($urandom_range(0, 2097151)) - 1048576;
      default: v = longint'($urandom_range(0, 127));
    endcase
    return v;
  endfunction

  // Scoreboard monitor: compare presented output with queue head; pop on handshake.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check("err_count", 64'(err_count), 64'(exp_cnt));
      check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got instr %h with empty scoreboard", out_instr);
        end else begin
          check("out_instr", 64'(out_instr), 64'(q[0].instr));
          check("out_err", 64'(out_err), 64'(q[0].err));
          if (out_ready) begin
`ifdef IMM_PACKER_ERR_CNT_EN
            if (q[0].err && exp_cnt < MAXC) exp_cnt++;
`endif
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Driver tasks start and return at one time step after a rising edge.
  task automatic send(input logic [2:0] f, input logic [63:0] imm, input logic [31:0] tmpl);
    exp_t e;
    logic acc;
    int   n;
    ref_model(f, imm, tmpl, e);
    in_valid = 1'b1; in_fmt = f; in_imm = imm; in_instr = tmpl;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    if (acc) q.push_back(e);
    else begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready in %0d cycles, required accept", n);
    end
    #1;
    in_valid = 1'b0;
    in_fmt   = 3'($urandom);
    in_imm   = {$urandom, $urandom};
    in_instr = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q.delete();
    exp_cnt = 0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_fmt    = '0;
    in_imm    = '0;
    in_instr  = '0;
    out_ready = 1'b1;
    #2;
    do_reset();

    // I-format all-ones immediate; output appears exactly two cycles after accept.
    send(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0013);
    @(negedge clk);
    check("latency_c1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_c2_valid", 64'(out_valid), 64'd1);
    check("req031_instr", 64'(out_instr), 64'hFFF0_0013);
    @(posedge clk);
    #1;

    // Branch offsets: even in range, then odd.
    send(3'd2, -64'sd4, 32'h0000_0063);
    send(3'd2, -64'sd3, 32'h0000_0063);
    drain();

    // U-format with nonzero low bits; counter starts from a fresh reset.
    do_reset();
    send(3'd3, 64'h1234_5001, 32'h0000_0037);
    drain();
    @(negedge clk);
`ifdef IMM_PACKER_ERR_CNT_EN
    check("req033_err_count", 64'(err_count), 64'd1);
`else
    check("req033_err_count", 64'(err_count), 64'd0);
`endif
    @(posedge clk);
    #1;

    // Back-to-back SHAMT with a 3-cycle stall.
    out_ready = 1'b0;
    send(3'd5, 64'd63, 32'h0000_1013);
    send(3'd5, 64'd64, 32'h0000_1013);
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset with both stages full discards them.
    out_ready = 1'b0;
    send(3'd0, 64'd5, 32'h0000_0013);
    send(3'd0, 64'd6, 32'h0000_0013);
    do_reset();
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Reserved format repeated; the narrow counter saturates.
    do_reset();
    repeat (5) send(3'd7, {$urandom, $urandom}, $urandom);
    drain();
    @(negedge clk);
`ifdef IMM_PACKER_ERR_CNT_EN
    check("req036_err_count", 64'(err_count), 64'(MAXC));
`else
    check("req036_err_count", 64'(err_count), 64'd0);
`endif
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and idle gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(3'($urandom_range(0, 7)), rand_imm(), $urandom);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
